video_vram_arbiter: RTL and testbench
=====================================

# video_vram_arbiter

Owns the PPU's single 14-bit VRAM port and shares it between two requesters: the host register path ($2006 PPUADDR / $2007 PPUDATA semantics) and the background/sprite fetch logic. It holds the VRAM address register `v`, its staging copy `t` and the write toggle. It also holds the buffered host read register. It sequences every VRAM access through a small slot state machine. It sits between the register decoder/edge triggers of the video top level and the `O_vid_addr`/`O_vid_wren`/`I_vid_data`/`O_vid_data` pins.

## Interface
No parameters.
- `I_clock`  in  1  system clock; the only clock.
- `I_reset`  in  1  synchronous, active-high reset.
- `I_host_wren`  in  1  one-cycle, already edge-detected host write strobe.
- `I_host_rden`  in  1  one-cycle, already edge-detected host read strobe.
- `I_sel_addr`  in  1  PPUADDR register selected.
- `I_sel_data`  in  1  PPUDATA register selected.
- `I_sel_stat`  in  1  PPUSTATUS register selected; a read of it clears the toggle.
- `I_host_data`  in  8  host write data.
- `I_inc32`  in  1  PPUCTRL bit 2: 0 selects increment +1, 1 selects increment +32.
- `O_host_data`  out  8  PPUDATA read value (the buffered byte).
- `O_host_busy`  out  1  a host data access is pending or in flight.
- `I_rnd_req`  in  1  renderer fetch request; held high until ack.
- `I_rnd_addr`  in  14  renderer fetch address; stable while `I_rnd_req` is high.
- `O_rnd_ack`  out  1  one-cycle fetch completion.
- `O_rnd_data`  out  8  fetched byte; valid while `O_rnd_ack` is high and held afterwards.
- `O_vid_addr`  out  14  VRAM address, registered.
- `O_vid_wren`  out  1  VRAM write enable, registered.
- `I_vid_data`  in  8  VRAM read data; valid one cycle after the address.
- `O_vid_data`  out  8  VRAM write data, registered.

## Operation
- PPUADDR write, toggle=0: `t[13:8]` ← `data[5:0]`; toggle ← 1.
- PPUADDR write, toggle=1: `t[7:0]` ← data; `v` ← new `t`; toggle ← 0; `addr_dirty` ← 1.
- PPUSTATUS read: toggle ← 0.
- PPUDATA write, not busy: capture op=WR, `a` ← `v`, `d` ← data; `addr_dirty` ← 0; busy ← 1.
- PPUDATA read, not busy: `O_host_data` ← read buffer on the next edge; capture op=RD, `a` ← `v`; `addr_dirty` ← 0; busy ← 1.
- PPUDATA access while busy: dropped. No state changes and `O_host_data` is unchanged.
- Slot state machine:
  - IDLE → R_ACC if `I_rnd_req` is high. The renderer has priority, except as noted under Configuration.
  - Otherwise IDLE → H_WR if a WR op is pending, or → H_ACC if an RD op is pending.
  - Otherwise IDLE → IDLE, with `O_vid_wren`=0 and `O_vid_addr` holding its value.
- R_ACC: `O_vid_addr` = `I_rnd_addr`, `O_vid_wren`=0. Then → R_DAT.
- R_DAT: `O_rnd_data` ← `I_vid_data`, and `O_rnd_ack`=1 in the following cycle. Then → IDLE.
- H_WR: `O_vid_addr` = `a`, `O_vid_data` = `d`, `O_vid_wren`=1 for exactly one cycle. Then → H_END.
- H_ACC: `O_vid_addr` = `a`. Then → H_DAT.
- H_DAT: read buffer ← `I_vid_data`. Then → H_END.
- H_END: if `addr_dirty`=0, `v` ← `a` + inc; otherwise `v` keeps the newer host value. busy ← 0. Then → IDLE.
- Increment arithmetic: inc is 1 or 32, chosen by `I_inc32` sampled in H_END. The sum is modulo 2^14, so 0x3FFF+1 → 0x0000 and 0x3FE0+32 → 0x0000.

## Timing
- Reset values: `v`=`t`=0, toggle=0, buffer=0, `O_host_data`=0, `O_host_busy`=0, `O_rnd_ack`=0, `O_rnd_data`=0, `O_vid_addr`=0, `O_vid_wren`=0, `O_vid_data`=0, state IDLE.
- Reset mid-operation: the in-flight op is discarded. No ack is issued and no write is issued after the reset edge.
- Renderer fetch: request seen in IDLE at cycle S → address driven in cycle S+1 → data sampled in cycle S+2 → `O_rnd_ack` high in cycle S+3.
  - The minimum fetch period is 3 cycles.
  - The renderer may re-raise its request in cycle S+4.
- Host write: strobe at cycle H → busy from H+1. With an idle arbiter, `O_vid_wren`=1 in cycle H+2 and busy clears after cycle H+3.
- Host read: the buffered value appears in `O_host_data` at H+1. The buffer refill and `v` increment complete by H+4 when the arbiter is idle.
- Simultaneous host strobe and renderer request: the host op is captured and the renderer is granted first.

## Configuration
- `VIDEO_VRAM_STARVE_GUARD_EN`
- Defined: a 4-bit counter runs while a host op is pending and the renderer wins IDLE arbitration. When the count reaches 15, the next IDLE grant goes to the host. The counter clears on every host grant.
- Undefined: strict renderer priority. A host op waits until a cycle in IDLE with `I_rnd_req`=0.

## Test plan
- PPUADDR writes 0x21, 0x08; PPUDATA write 0x5A with inc32=0 → one VRAM write at addr 0x2108, data 0x5A; `v` = 0x2109.
- PPUADDR 0x3F, 0xE0 with inc32=1; two PPUDATA reads, memory[0x3FE0]=0x11 and memory[0x0000]=0x22 → first read returns 0 (reset buffer), second read returns 0x11; `v` = 0x0020 (wraps).
- PPUADDR single write 0x12, then PPUSTATUS read, then PPUADDR 0x23, 0x45 → `t`/`v` = 0x2345.
- `I_rnd_req` held high continuously with `I_rnd_addr` = 0x0ABC → ack every 3 cycles with `O_rnd_data` = memory[0x0ABC]; no host access ever issued without the guard.
- Same as previous plus a pending PPUDATA write, built with `VIDEO_VRAM_STARVE_GUARD_EN` defined → host write issued after 15 renderer grants; renderer resumes afterwards.
- PPUDATA write then a second write while busy → exactly one VRAM write occurs; the second is dropped. Assert `I_reset` during H_ACC → no write, busy=0, all outputs return to reset values.

Source files
------------

// File: rtl/video_vram_arbiter_if.sv
// Signal bundle between the PPU register/render logic, the VRAM arbiter and the VRAM pins.
// The slave modport is the arbiter; the master modport is everything around it.
interface video_vram_arbiter_if;
    logic        I_host_wren;
    logic        I_host_rden;
    logic        I_sel_addr;
    logic        I_sel_data;
    logic        I_sel_stat;
    logic [7:0]  I_host_data;
    logic        I_inc32;
    logic [7:0]  O_host_data;
    logic        O_host_busy;
    logic        I_rnd_req;
    logic [13:0] I_rnd_addr;
    logic        O_rnd_ack;
    logic [7:0]  O_rnd_data;
    logic [13:0] O_vid_addr;
    logic        O_vid_wren;
    logic [7:0]  I_vid_data;
    logic [7:0]  O_vid_data;

    modport slave (
        input  I_host_wren, I_host_rden, I_sel_addr, I_sel_data, I_sel_stat,
        input  I_host_data, I_inc32, I_rnd_req, I_rnd_addr, I_vid_data,
        output O_host_data, O_host_busy, O_rnd_ack, O_rnd_data,
        output O_vid_addr, O_vid_wren, O_vid_data
    );

    modport master (
        output I_host_wren, I_host_rden, I_sel_addr, I_sel_data, I_sel_stat,
        output I_host_data, I_inc32, I_rnd_req, I_rnd_addr, I_vid_data,
        input  O_host_data, O_host_busy, O_rnd_ack, O_rnd_data,
        input  O_vid_addr, O_vid_wren, O_vid_data
    );
endinterface

// File: rtl/video_vram_arbiter.sv
// PPU VRAM port arbiter: host v/t/toggle registers, buffered reads, renderer fetch slots.
// Define VIDEO_VRAM_STARVE_GUARD_EN to force a host slot after 15 contested renderer grants.
module video_vram_arbiter (
    input logic           I_clock,
    input logic           I_reset,
    video_vram_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_R_ACC,
        S_R_DAT,
        S_H_WR,
        S_H_ACC,
        S_H_DAT,
        S_H_END
    } state_t;

    state_t      state_q, state_d;
    logic [13:0] v_q, v_d;
    logic [13:0] t_q, t_d;
    logic        tog_q, tog_d;
    logic [7:0]  rbuf_q, rbuf_d;
    logic [7:0]  hdata_q, hdata_d;
    logic        busy_q, busy_d;
    logic        op_wr_q, op_wr_d;
    logic [13:0] a_q, a_d;
    logic [7:0]  dat_q, dat_d;
    logic        dirty_q, dirty_d;
    logic        ack_q, ack_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [13:0] vaddr_q, vaddr_d;
    logic        wren_q, wren_d;
    logic [7:0]  vdata_q, vdata_d;

    logic        idle;
    logic        host_first;
    logic        rnd_grant;
    logic        host_grant;
    logic        addr_wr;
    logic        stat_rd;
    logic        data_wr;
    logic        data_rd;
    logic [13:0] inc;

    // An op is pending exactly when busy is set while the slot machine sits in IDLE.
    assign idle       = (state_q == S_IDLE);
    assign rnd_grant  = idle && bus.I_rnd_req && !host_first;
    assign host_grant = idle && busy_q && !rnd_grant;

    assign addr_wr = bus.I_host_wren && bus.I_sel_addr;
    assign stat_rd = bus.I_host_rden && bus.I_sel_stat;
    assign data_wr = bus.I_host_wren && bus.I_sel_data && !busy_q;
    assign data_rd = bus.I_host_rden && bus.I_sel_data && !busy_q;
    assign inc     = bus.I_inc32 ? 14'd32 : 14'd1;

`ifdef VIDEO_VRAM_STARVE_GUARD_EN
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (host_grant) begin
            cnt_d = 4'd0;
        end else if (rnd_grant && busy_q) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign host_first = busy_q && (cnt_q == 4'd15);
`else
    assign host_first = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        t_d     = t_q;
        tog_d   = tog_q;
        rbuf_d  = rbuf_q;
        hdata_d = hdata_q;
        busy_d  = busy_q;
        op_wr_d = op_wr_q;
        a_d     = a_q;
        dat_d   = dat_q;
        dirty_d = dirty_q;
        ack_d   = 1'b0;
        rdata_d = rdata_q;
        vaddr_d = vaddr_q;
        wren_d  = 1'b0;
        vdata_d = vdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (rnd_grant) begin
                    state_d = S_R_ACC;
                    vaddr_d = bus.I_rnd_addr;
                end else if (host_grant) begin
                    vaddr_d = a_q;
                    if (op_wr_q) begin
                        state_d = S_H_WR;
                        vdata_d = dat_q;
                        wren_d  = 1'b1;
                    end else begin
                        state_d = S_H_ACC;
                    end
                end
            end
            S_R_ACC: state_d = S_R_DAT;
            S_R_DAT: begin
                rdata_d = bus.I_vid_data;
                ack_d   = 1'b1;
                state_d = S_IDLE;
            end
            S_H_WR:  state_d = S_H_END;
            S_H_ACC: state_d = S_H_DAT;
            S_H_DAT: begin
                rbuf_d  = bus.I_vid_data;
                state_d = S_H_END;
            end
            S_H_END: begin
                if (!dirty_q) begin
                    v_d = a_q + inc;
                end
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Register writes come after the increment so a same-cycle v reload wins.
        if (addr_wr) begin
            if (!tog_q) begin
                t_d[13:8] = bus.I_host_data[5:0];
                tog_d     = 1'b1;
            end else begin
                t_d[7:0] = bus.I_host_data;
                v_d      = {t_q[13:8], bus.I_host_data};
                tog_d    = 1'b0;
                dirty_d  = 1'b1;
            end
        end
        if (stat_rd) begin
            tog_d = 1'b0;
        end
        if (data_wr) begin
            op_wr_d = 1'b1;
            a_d     = v_q;
            dat_d   = bus.I_host_data;
            dirty_d = 1'b0;
            busy_d  = 1'b1;
        end
        if (data_rd) begin
            hdata_d = rbuf_q;
            op_wr_d = 1'b0;
            a_d     = v_q;
            dirty_d = 1'b0;
            busy_d  = 1'b1;
        end
    end

    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            state_q <= S_IDLE;
            v_q     <= 14'd0;
            t_q     <= 14'd0;
            tog_q   <= 1'b0;
            rbuf_q  <= 8'd0;
            hdata_q <= 8'd0;
            busy_q  <= 1'b0;
            op_wr_q <= 1'b0;
            a_q     <= 14'd0;
            dat_q   <= 8'd0;
            dirty_q <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= 8'd0;
            vaddr_q <= 14'd0;
            wren_q  <= 1'b0;
            vdata_q <= 8'd0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            t_q     <= t_d;
            tog_q   <= tog_d;
            rbuf_q  <= rbuf_d;
            hdata_q <= hdata_d;
            busy_q  <= busy_d;
            op_wr_q <= op_wr_d;
            a_q     <= a_d;
            dat_q   <= dat_d;
            dirty_q <= dirty_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            vaddr_q <= vaddr_d;
            wren_q  <= wren_d;
            vdata_q <= vdata_d;
        end
    end

    assign bus.O_host_data = hdata_q;
    assign bus.O_host_busy = busy_q;
    assign bus.O_rnd_ack   = ack_q;
    assign bus.O_rnd_data  = rdata_q;
    assign bus.O_vid_addr  = vaddr_q;
    assign bus.O_vid_wren  = wren_q;
    assign bus.O_vid_data  = vdata_q;

endmodule

// File: tb/tb_video_vram_arbiter.sv
// Bench for video_vram_arbiter: VRAM model, register-level reference model, scenario tasks.
// Build with VIDEO_VRAM_STARVE_GUARD_EN defined to check the starvation guard variant.
module tb_video_vram_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    video_vram_arbiter_if bus();

    video_vram_arbiter dut (
        .I_clock (clk),
        .I_reset (rst),
        .bus     (bus)
    );

    // VRAM device: synchronous read, write on the edge ending a wren cycle
    logic [7:0]  vram [16384];
    logic [21:0] wr_log [$];

    always @(posedge clk) begin
        bus.I_vid_data <= vram[bus.O_vid_addr];
        if (bus.O_vid_wren) begin
            vram[bus.O_vid_addr] = bus.O_vid_data;
            wr_log.push_back({bus.O_vid_addr, bus.O_vid_data});
        end
    end

    // Reference model: register semantics applied one host op at a time
    logic [7:0]  mmem [16384];
    logic [13:0] m_t;
    logic [13:0] m_v;
    logic        m_tog;
    logic [7:0]  m_buf;
    logic [21:0] exp_q [$];

    function automatic void m_reset();
        m_t = 0;
        m_v = 0;
        m_tog = 0;
        m_buf = 0;
    endfunction

    function automatic int m_step();
        return bus.I_inc32 ? 32 : 1;
    endfunction

    function automatic void m_addr(input logic [7:0] d);
        if (!m_tog) begin
            m_t = (m_t & 14'h00FF) | (14'(d & 8'h3F) << 8);
            m_tog = 1;
        end else begin
            m_t = (m_t & 14'h3F00) | 14'(d);
            m_v = m_t;
            m_tog = 0;
        end
    endfunction

    function automatic void m_wr(input logic [7:0] d);
        exp_q.push_back({m_v, d});
        mmem[m_v] = d;
        m_v = 14'((int'(m_v) + m_step()) % 16384);
    endfunction

    function automatic logic [7:0] m_rd();
        logic [7:0] r;
        r = m_buf;
        m_buf = mmem[m_v];
        m_v = 14'((int'(m_v) + m_step()) % 16384);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_host();
        bus.I_host_wren = 0;
        bus.I_host_rden = 0;
        bus.I_sel_addr = 0;
        bus.I_sel_data = 0;
        bus.I_sel_stat = 0;
        bus.I_host_data = 0;
    endtask

    task automatic do_reset();
        clr_host();
        bus.I_inc32 = 0;
        bus.I_rnd_req = 0;
        bus.I_rnd_addr = 0;
        rst = 1;
        tick();
        tick();
        rst = 0;
        m_reset();
        wr_log.delete();
        exp_q.delete();
    endtask

    task automatic strobe(input bit wr, input bit sa, input bit sd,
                          input bit ss, input logic [7:0] d);
        bus.I_host_wren = wr;
        bus.I_host_rden = !wr;
        bus.I_sel_addr = sa;
        bus.I_sel_data = sd;
        bus.I_sel_stat = ss;
        bus.I_host_data = d;
        tick();
        clr_host();
    endtask

    task automatic wait_idle(input string tag);
        bit done = 0;
        for (int i = 0; i < 200; i++) begin
            if (!bus.O_host_busy) begin
                done = 1;
                break;
            end
            tick();
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s busy_timeout got busy=1 want 0", tag);
        end
    endtask

    task automatic h_addr(input logic [7:0] d);
        strobe(1, 1, 0, 0, d);
        m_addr(d);
    endtask

    task automatic h_stat();
        strobe(0, 0, 0, 1, 8'h00);
        m_tog = 0;
    endtask

    task automatic h_wr(input logic [7:0] d);
        strobe(1, 0, 1, 0, d);
        m_wr(d);
        wait_idle("h_wr");
    endtask

    task automatic h_rd(output logic [7:0] got, output logic [7:0] want);
        strobe(0, 0, 1, 0, 8'h00);
        got = bus.O_host_data;
        want = m_rd();
        wait_idle("h_rd");
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (bus.O_host_data !== 8'h00) begin
            n_err++;
            $display("FAIL rst_host_data got %h want 00", bus.O_host_data);
        end
        n_cmp++;
        if (bus.O_host_busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_busy got %b want 0", bus.O_host_busy);
        end
        n_cmp++;
        if (bus.O_rnd_ack !== 1'b0 || bus.O_rnd_data !== 8'h00) begin
            n_err++;
            $display("FAIL rst_rnd got %b/%h want 0/00", bus.O_rnd_ack, bus.O_rnd_data);
        end
        n_cmp++;
        if ({bus.O_vid_addr, bus.O_vid_wren, bus.O_vid_data} !== 23'd0) begin
            n_err++;
            $display("FAIL rst_vid got %h/%b/%h want 0/0/0",
                     bus.O_vid_addr, bus.O_vid_wren, bus.O_vid_data);
        end
    endtask

    task automatic test_host_write();
        do_reset();
        h_addr(8'h21);
        h_addr(8'h08);
        strobe(1, 0, 1, 0, 8'h5A);
        m_wr(8'h5A);
        n_cmp++;
        if (bus.O_host_busy !== 1'b1) begin
            n_err++;
            $display("FAIL wr_busy_h1 got %b want 1", bus.O_host_busy);
        end
        tick();
        n_cmp++;
        if ({bus.O_vid_wren, bus.O_vid_addr, bus.O_vid_data} !== {1'b1, exp_q[0]}) begin
            n_err++;
            $display("FAIL wr_pins_h2 got %b/%h/%h want 1/%h",
                     bus.O_vid_wren, bus.O_vid_addr, bus.O_vid_data, exp_q[0]);
        end
        tick();
        n_cmp++;
        if (bus.O_vid_wren !== 1'b0 || bus.O_host_busy !== 1'b1) begin
            n_err++;
            $display("FAIL wr_h3 got wren=%b busy=%b want 0/1",
                     bus.O_vid_wren, bus.O_host_busy);
        end
        tick();
        n_cmp++;
        if (bus.O_host_busy !== 1'b0) begin
            n_err++;
            $display("FAIL wr_busy_h4 got %b want 0", bus.O_host_busy);
        end
        h_wr(8'h33);
        n_cmp++;
        if (wr_log.size() != 2) begin
            n_err++;
            $display("FAIL wr_count got %0d want 2", wr_log.size());
        end else if (wr_log[1] !== exp_q[1]) begin
            n_err++;
            $display("FAIL wr_v_inc got %h want %h", wr_log[1], exp_q[1]);
        end
    endtask

    task automatic test_read_wrap();
        logic [7:0] got, want;
        do_reset();
        bus.I_inc32 = 1;
        vram[14'h3FE0] = 8'h11;
        mmem[14'h3FE0] = 8'h11;
        vram[14'h0000] = 8'h22;
        mmem[14'h0000] = 8'h22;
        h_addr(8'h3F);
        h_addr(8'hE0);
        for (int k = 0; k < 2; k++) begin
            h_rd(got, want);
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL rd_wrap_%0d got %h want %h", k, got, want);
            end
        end
        h_wr(8'h44);
        n_cmp++;
        if (wr_log.size() != 1 || wr_log[0] !== exp_q[0]) begin
            n_err++;
            $display("FAIL rd_wrap_v got %0d/%h want 1/%h",
                     wr_log.size(), wr_log.size() ? wr_log[0] : 22'h0, exp_q[0]);
        end
    endtask

    task automatic test_toggle();
        do_reset();
        bus.I_inc32 = 1'($urandom);
        h_addr(8'h12);
        h_stat();
        h_addr(8'h23);
        h_addr(8'h45);
        h_wr(8'($urandom));
        n_cmp++;
        if (wr_log.size() != 1 || wr_log[0] !== exp_q[0]) begin
            n_err++;
            $display("FAIL toggle_addr got %0d/%h want 1/%h",
                     wr_log.size(), wr_log.size() ? wr_log[0] : 22'h0, exp_q[0]);
        end
    endtask

    task automatic test_dirty();
        do_reset();
        h_addr(8'h01);
        h_addr(8'h00);
        h_addr(8'h15);
        strobe(1, 0, 1, 0, 8'hA1);
        m_wr(8'hA1);
        h_addr(8'h67);
        wait_idle("dirty");
        h_wr(8'hB2);
        n_cmp++;
        if (wr_log.size() != 2) begin
            n_err++;
            $display("FAIL dirty_count got %0d want 2", wr_log.size());
        end else if (wr_log[0] !== exp_q[0] || wr_log[1] !== exp_q[1]) begin
            n_err++;
            $display("FAIL dirty_addr got %h,%h want %h,%h",
                     wr_log[0], wr_log[1], exp_q[0], exp_q[1]);
        end
    endtask

    task automatic test_busy_drop();
        logic [7:0] hd;
        do_reset();
        h_addr(8'($urandom));
        h_addr(8'($urandom));
        hd = bus.O_host_data;
        strobe(1, 0, 1, 0, 8'hC3);
        m_wr(8'hC3);
        strobe(1, 0, 1, 0, 8'h3C);
        strobe(0, 0, 1, 0, 8'h00);
        n_cmp++;
        if (bus.O_host_data !== hd) begin
            n_err++;
            $display("FAIL drop_rd_data got %h want %h", bus.O_host_data, hd);
        end
        wait_idle("drop");
        n_cmp++;
        if (wr_log.size() != 1 || wr_log[0] !== exp_q[0]) begin
            n_err++;
            $display("FAIL drop_writes got %0d/%h want 1/%h",
                     wr_log.size(), wr_log.size() ? wr_log[0] : 22'h0, exp_q[0]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        h_addr(8'h15);
        h_addr(8'($urandom) | 8'h01);
        strobe(0, 0, 1, 0, 8'h00);
        tick();
        rst = 1;
        tick();
        rst = 0;
        n_cmp++;
        if ({bus.O_host_busy, bus.O_vid_addr, bus.O_vid_wren} !== 16'd0) begin
            n_err++;
            $display("FAIL midrst_rd got busy=%b addr=%h wren=%b want 0/0/0",
                     bus.O_host_busy, bus.O_vid_addr, bus.O_vid_wren);
        end
        n_cmp++;
        if ({bus.O_host_data, bus.O_rnd_ack, bus.O_rnd_data, bus.O_vid_data} !== 25'd0) begin
            n_err++;
            $display("FAIL midrst_out got %h/%b/%h/%h want 0",
                     bus.O_host_data, bus.O_rnd_ack, bus.O_rnd_data, bus.O_vid_data);
        end
        wr_log.delete();
        strobe(1, 0, 1, 0, 8'h77);
        rst = 1;
        tick();
        rst = 0;
        for (int i = 0; i < 6; i++) tick();
        n_cmp++;
        if (wr_log.size() != 0 || bus.O_host_busy !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_wr got writes=%0d busy=%b want 0/0",
                     wr_log.size(), bus.O_host_busy);
        end
        m_reset();
    endtask

    task automatic test_rnd_stream();
        int s, last, nack, nbad, ngap, nbefore, nafter;
        bit seen_w;
        logic [7:0] want, d;
        do_reset();
        want = 8'($urandom);
        vram[14'h0ABC] = want;
        mmem[14'h0ABC] = want;
        h_addr(8'h01);
        h_addr(8'h23);
        d = 8'($urandom);
        bus.I_rnd_addr = 14'h0ABC;
        bus.I_rnd_req = 1;
        bus.I_host_wren = 1;
        bus.I_sel_data = 1;
        bus.I_host_data = d;
        m_wr(d);
        s = cyc;
        tick();
        clr_host();
        n_cmp++;
        if (bus.O_host_busy !== 1'b1 || bus.O_vid_addr !== 14'h0ABC) begin
            n_err++;
            $display("FAIL stream_first got busy=%b addr=%h want 1/0abc",
                     bus.O_host_busy, bus.O_vid_addr);
        end
        last = -1;
        nack = 0;
        nbad = 0;
        ngap = 0;
        nbefore = 0;
        nafter = 0;
        seen_w = 0;
        for (int i = 0; i < 80; i++) begin
            if (bus.O_vid_wren) seen_w = 1;
            if (bus.O_rnd_ack) begin
                if (nack == 0 && cyc != s + 3) nbad++;
                if (bus.O_rnd_data !== want) nbad++;
                if (last >= 0 && cyc - last != 3) ngap++;
                if (seen_w) nafter++;
                else nbefore++;
                last = cyc;
                nack++;
            end
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            if (bus.O_rnd_ack) break;
            tick();
        end
        bus.I_rnd_req = 0;
        wait_idle("stream");
        n_cmp++;
        if (nbad != 0) begin
            n_err++;
            $display("FAIL stream_ack_data got %0d bad acks want 0", nbad);
        end
`ifdef VIDEO_VRAM_STARVE_GUARD_EN
        n_cmp++;
        if (nbefore != 16 || nafter == 0 || ngap != 1) begin
            n_err++;
            $display("FAIL guard_slot got before=%0d after=%0d gaps=%0d want 16/>0/1",
                     nbefore, nafter, ngap);
        end
`else
        n_cmp++;
        if (seen_w || nack != 26 || ngap != 0) begin
            n_err++;
            $display("FAIL strict_prio got w=%b acks=%0d gaps=%0d want 0/26/0",
                     seen_w, nack, ngap);
        end
`endif
        n_cmp++;
        if (wr_log.size() != 1 || wr_log[0] !== exp_q[0]) begin
            n_err++;
            $display("FAIL stream_host_wr got %0d/%h want 1/%h",
                     wr_log.size(), wr_log.size() ? wr_log[0] : 22'h0, exp_q[0]);
        end
    endtask

    task automatic test_random();
        logic [7:0] got, want;
        int nbad = 0;
        do_reset();
        for (int k = 0; k < 80; k++) begin
            bus.I_inc32 = 1'($urandom);
            case ($urandom_range(0, 3))
                0: h_addr(8'($urandom));
                1: h_stat();
                2: h_wr(8'($urandom));
                default: begin
                    h_rd(got, want);
                    n_cmp++;
                    if (got !== want) begin
                        n_err++;
                        $display("FAIL rand_rd_%0d got %h want %h", k, got, want);
                    end
                end
            endcase
        end
        n_cmp++;
        if (wr_log.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL rand_wr_count got %0d want %0d", wr_log.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) if (wr_log[i] !== exp_q[i]) nbad++;
            if (nbad != 0) begin
                n_err++;
                $display("FAIL rand_wr_list got %0d wrong entries want 0", nbad);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin
            vram[i] = 8'($urandom);
            mmem[i] = vram[i];
        end
        test_reset();
        test_host_write();
        test_read_wrap();
        test_toggle();
        test_dirty();
        test_busy_drop();
        test_reset_mid();
        test_rnd_stream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
